substitution_layer_serial: RTL and testbench

SUBSTITUTION_LAYER_SERIAL -- requirements
Module: substitution_layer_serial

---
 rtl/ascon_pack.sv | 17 +
 rtl/sbox.sv | 33 +++
 rtl/substitution_layer_serial.sv | 99 +++++++++
 tb/tb_substitution_layer_serial.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pack.sv
// Shared Ascon definitions: the 320-bit permutation state as five 64-bit words
// and the sequencing states of the serial substitution layer.
package ascon_pack;

   localparam int NUM_WORDS = 5;
   localparam int WORD_W    = 64;

   // Word index 0 holds x0, index 4 holds x4.
   typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } type_sub_fsm;

endpackage

// File: rtl/sbox.sv
// Ascon 5-bit S-box in its bitsliced boolean form; input and output are
// ordered {x0,x1,x2,x3,x4} with x0 as MSB.
module sbox (
   input  logic [4:0] sbox_i,
   output logic [4:0] sbox_o
);

   logic a0, a1, a2, a3, a4;
   logic t0, t1, t2, t3, t4;
   logic b0, b1, b2, b3, b4;

   assign a0 = sbox_i[4] ^ sbox_i[0];
   assign a1 = sbox_i[3];
   assign a2 = sbox_i[2] ^ sbox_i[3];
   assign a3 = sbox_i[1];
   assign a4 = sbox_i[0] ^ sbox_i[1];

   // Chi-like nonlinear layer.
   assign t0 = ~a0 & a1;
   assign t1 = ~a1 & a2;
   assign t2 = ~a2 & a3;
   assign t3 = ~a3 & a4;
   assign t4 = ~a4 & a0;

   assign b0 = a0 ^ t1;
   assign b1 = a1 ^ t2;
   assign b2 = a2 ^ t3;
   assign b3 = a3 ^ t4;
   assign b4 = a4 ^ t0;

   assign sbox_o = {b0 ^ b4, b1 ^ b0, ~b2, b3 ^ b2, b4};

endmodule

// File: rtl/substitution_layer_serial.sv
// Ascon substitution layer applied COLS_PER_CYCLE columns per clock over a
// 64-column working register, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | result held on state_o, waiting for start_i
// RUN   | substituting one column group per clock
// DONE  | one-cycle completion pulse, start_i accepted without a bubble
module substitution_layer_serial
   import ascon_pack::*;
#(
   parameter int COLS_PER_CYCLE = 4
) (
   input  logic      clock_i,
   input  logic      resetb_i,
   input  logic      start_i,
   input  type_state state_i,
   output type_state state_o,
   output logic      busy_o,
   output logic      done_o
);

   localparam int GROUPS = WORD_W / COLS_PER_CYCLE;
   localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

   type_sub_fsm      fsm_q, fsm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   type_state        work_q, work_d;
   type_state        sub_state;
   logic [5:0]       base_col;
   logic [4:0]       col_in  [COLS_PER_CYCLE];
   logic [4:0]       col_out [COLS_PER_CYCLE];

   assign base_col = 6'(int'(cnt_q) * COLS_PER_CYCLE);

   for (genvar j = 0; j < COLS_PER_CYCLE; j++) begin : g_lane
      logic [5:0] col_idx;
      assign col_idx = base_col + 6'(j);
      for (genvar w = 0; w < NUM_WORDS; w++) begin : g_gather
         assign col_in[j][4-w] = work_q[w][col_idx];
      end
      sbox u_sbox (
         .sbox_i (col_in[j]),
         .sbox_o (col_out[j])
      );
   end

   // Column k belongs to group k/COLS_PER_CYCLE, lane k%COLS_PER_CYCLE.
   for (genvar k = 0; k < WORD_W; k++) begin : g_col
      for (genvar w = 0; w < NUM_WORDS; w++) begin : g_word
         assign sub_state[w][k] = (cnt_q == CNT_W'(k / COLS_PER_CYCLE))
                                ? col_out[k % COLS_PER_CYCLE][4-w]
                                : work_q[w][k];
      end
   end

   always_comb begin
      fsm_d  = fsm_q;
      cnt_d  = cnt_q;
      work_d = work_q;
      case (fsm_q)
         IDLE, DONE: begin
            if (start_i) begin
               work_d = state_i;
               cnt_d  = '0;
               fsm_d  = RUN;
            end else begin
               fsm_d  = IDLE;
            end
         end
         RUN: begin
            work_d = sub_state;
            if (cnt_q == CNT_LAST) begin
               fsm_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: fsm_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         fsm_q  <= IDLE;
         cnt_q  <= '0;
         work_q <= '0;
      end else begin
         fsm_q  <= fsm_d;
         cnt_q  <= cnt_d;
         work_q <= work_d;
      end
   end

   assign state_o = work_q;
   assign busy_o  = (fsm_q == RUN);
   assign done_o  = (fsm_q == DONE);

endmodule

// File: tb/tb_substitution_layer_serial.sv
// Scoreboard bench for the serial substitution layer at 4, 1 and 64 columns
// per cycle; expected results come from the hand-entered Ascon S-box table.
module tb_substitution_layer_serial;
   import ascon_pack::*;

   localparam logic [4:0] SBOX_T [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };

   typedef struct {
      type_state st;
      int        due;
   } exp_t;

   logic      clk = 1'b0;
   logic      resetb;
   logic      start4, start1, start64;
   type_state state_in;
   type_state st4, st1, st64;
   logic      busy4, busy1, busy64;
   logic      done4, done1, done64;

   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   done_seen4 = 0;
   exp_t q4[$], q1[$], q64[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   substitution_layer_serial #(.COLS_PER_CYCLE(4)) u_dut4 (
      .clock_i(clk), .resetb_i(resetb), .start_i(start4), .state_i(state_in),
      .state_o(st4), .busy_o(busy4), .done_o(done4));
   substitution_layer_serial #(.COLS_PER_CYCLE(1)) u_dut1 (
      .clock_i(clk), .resetb_i(resetb), .start_i(start1), .state_i(state_in),
      .state_o(st1), .busy_o(busy1), .done_o(done1));
   substitution_layer_serial #(.COLS_PER_CYCLE(64)) u_dut64 (
      .clock_i(clk), .resetb_i(resetb), .start_i(start64), .state_i(state_in),
      .state_o(st64), .busy_o(busy64), .done_o(done64));

   function automatic logic [4:0] col_of(input type_state s, input int k);
      logic [4:0] r;
      for (int w = 0; w < 5; w++) r[4-w] = s[w][k];
      return r;
   endfunction

   function automatic type_state model(input type_state s);
      type_state  r;
      logic [4:0] o;
      for (int k = 0; k < 64; k++) begin
         o = SBOX_T[col_of(s, k)];
         for (int w = 0; w < 5; w++) r[w][k] = o[4-w];
      end
      return r;
   endfunction

   function automatic type_state ramp();
      type_state  r;
      logic [4:0] v;
      for (int k = 0; k < 64; k++) begin
         v = 5'(k % 32);
         for (int w = 0; w < 5; w++) r[w][k] = v[4-w];
      end
      return r;
   endfunction

   task automatic cmp_state(input string name, input type_state act, input type_state exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got x0=%h x1=%h x2=%h x3=%h x4=%h want x0=%h x1=%h x2=%h x3=%h x4=%h",
                  name, act[0], act[1], act[2], act[3], act[4], exp[0], exp[1], exp[2], exp[3], exp[4]);
      end
   endtask

   task automatic cmp_int(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops and checks whenever any instance pulses done_o.
   always @(negedge clk) begin
      exp_t e;
      if (done4 === 1'b1) begin
         done_seen4++;
         if (q4.size() == 0) cmp_int("c4_unexpected_done", 1, 0);
         else begin
            e = q4.pop_front();
            cmp_state("c4_result", st4, e.st);
            cmp_int("c4_latency", cyc, e.due);
         end
      end
      if (done1 === 1'b1) begin
         if (q1.size() == 0) cmp_int("c1_unexpected_done", 1, 0);
         else begin
            e = q1.pop_front();
            cmp_state("c1_result", st1, e.st);
            cmp_int("c1_latency", cyc, e.due);
         end
      end
      if (done64 === 1'b1) begin
         if (q64.size() == 0) cmp_int("c64_unexpected_done", 1, 0);
         else begin
            e = q64.pop_front();
            cmp_state("c64_result", st64, e.st);
            cmp_int("c64_latency", cyc, e.due);
         end
      end
   end

   // Called on a falling edge; start is sampled at the next rising edge.
   task automatic issue(input logic d4, input logic d1, input logic d64,
                        input type_state s, input type_state e);
      state_in = s;
      start4   = d4;
      start1   = d1;
      start64  = d64;
      if (d4)  q4.push_back('{st: e, due: cyc + 1 + 16});
      if (d1)  q1.push_back('{st: e, due: cyc + 1 + 64});
      if (d64) q64.push_back('{st: e, due: cyc + 1 + 1});
      @(negedge clk);
      start4  = 1'b0;
      start1  = 1'b0;
      start64 = 1'b0;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n = 0;
      while ((q4.size() + q1.size() + q64.size()) != 0 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      cmp_int("drain_timeout_pending", q4.size() + q1.size() + q64.size(), 0);
      q4.delete();
      q1.delete();
      q64.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      type_state e_zero, e_ones, e_ramp, garbage;
      int        c0, seen;

      e_zero    = '0;
      e_zero[2] = '1;
      e_ones    = '1;
      e_ones[1] = '0;
      e_ramp    = model(ramp());

      resetb   = 1'b1;
      start4   = 1'b0;
      start1   = 1'b0;
      start64  = 1'b0;
      state_in = '0;
      #1 resetb = 1'b0;
      #1;
      cmp_state("reset_state4", st4, '0);
      cmp_state("reset_state1", st1, '0);
      cmp_int("reset_busy4", busy4, 0);
      cmp_int("reset_done4", done4, 0);
      repeat (3) @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);

      // All-zero state through all three widths.
      issue(1, 1, 1, '0, e_zero);
      cmp_int("busy_after_start4", busy4, 1);
      wait_drain(100);

      // All-ones state.
      issue(1, 1, 1, '1, e_ones);
      wait_drain(100);

      // Every S-box entry appears twice across the 64 columns.
      issue(1, 1, 1, ramp(), e_ramp);
      wait_drain(100);
      for (int k = 0; k < 32; k++) cmp_int("table_entry", col_of(st4, k), SBOX_T[k]);
      cmp_int("col1_is_0b", col_of(st4, 1), 5'h0b);
      cmp_int("col34_is_1f", col_of(st4, 34), 5'h1f);
      repeat (5) @(negedge clk);
      cmp_state("hold_in_idle", st4, e_ramp);
      cmp_int("idle_busy4", busy4, 0);
      cmp_int("idle_done4", done4, 0);

      // start held for 40 cycles: accepts at edges c0+1, c0+18, c0+35.
      seen = done_seen4;
      c0   = cyc;
      for (int i = 1; i <= 40; i++) begin
         garbage = {$urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, $urandom};
         start4 = 1'b1;
         if (i == 1)       state_in = '0;
         else if (i == 18) state_in = '1;
         else if (i == 35) state_in = ramp();
         else              state_in = garbage;
         if (i == 1)  q4.push_back('{st: e_zero, due: c0 + 17});
         if (i == 18) q4.push_back('{st: e_ones, due: c0 + 34});
         if (i == 35) q4.push_back('{st: e_ramp, due: c0 + 51});
         @(negedge clk);
         cmp_int("held_busy4", busy4, (cyc == c0 + 17 || cyc == c0 + 34) ? 0 : 1);
      end
      start4 = 1'b0;
      wait_drain(40);
      cmp_int("held_done_count", done_seen4 - seen, 3);

      // Reset asserted in the 7th RUN cycle.
      issue(1, 0, 0, ramp(), e_ramp);
      repeat (6) @(negedge clk);
      cmp_int("pre_reset_busy4", busy4, 1);
      #2 resetb = 1'b0;
      #1;
      cmp_state("midrun_reset_state", st4, '0);
      cmp_int("midrun_reset_busy", busy4, 0);
      cmp_int("midrun_reset_done", done4, 0);
      q4.delete();
      seen = done_seen4;
      repeat (2) @(negedge clk);
      resetb = 1'b1;
      repeat (70) @(negedge clk);
      cmp_int("no_resume_done", done_seen4 - seen, 0);
      cmp_int("no_resume_busy", busy4, 0);
      cmp_state("no_resume_state", st4, '0);

      // Fresh operation after reset.
      issue(1, 1, 1, '1, e_ones);
      wait_drain(100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
